// File: rtl/bp_me_mem_cmd_burst_collector.sv
// bp_me_mem_cmd_burst_collector: gathers a mem_cmd header plus its dword beats into one wide message
// Holds a single message; collection and send never overlap.
module bp_me_mem_cmd_burst_collector #(
    parameter int header_width_p = 64,
    parameter int data_width_p = 64,
    parameter int block_width_p = 512,
    parameter int size_lsb_p = 0,
    parameter int size_width_p = 3,
    parameter int msg_type_lsb_p = 3,
    parameter int msg_type_width_p = 4,
    parameter logic [(2**msg_type_width_p)-1:0] data_type_mask_p = 16'h0006
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [header_width_p-1:0] mem_cmd_header_i,
    input  logic                      mem_cmd_header_v_i,
    output logic                      mem_cmd_header_ready_o,
    input  logic [data_width_p-1:0]   mem_cmd_data_i,
    input  logic                      mem_cmd_data_v_i,
    output logic                      mem_cmd_data_ready_o,
    output logic [header_width_p-1:0] msg_header_o,
    output logic [block_width_p-1:0]  msg_data_o,
    output logic                      msg_v_o,
    input  logic                      msg_ready_i
);
    localparam int nb_lp = block_width_p / data_width_p;
    localparam int cw_lp = $clog2(nb_lp) + 1;

    typedef enum logic [1:0] {e_ready, e_data, e_send} state_e;

    state_e state, state_n;
    logic [cw_lp-1:0] cnt, beats_r, beats_n;
    logic [size_width_p-1:0] size;
    logic [msg_type_width_p-1:0] msg_type;
    logic [31:0] blk_bits, beats_raw;
    logic has_data, hdr_hs, data_hs, last_beat;

    assign size = mem_cmd_header_i[size_lsb_p +: size_width_p];
    assign msg_type = mem_cmd_header_i[msg_type_lsb_p +: msg_type_width_p];
    assign has_data = data_type_mask_p[msg_type];
    assign blk_bits = 32'd8 << size;
    assign beats_raw = blk_bits / 32'(data_width_p);
    // sub-dword sizes still need one beat; oversize requests saturate at a full block
    assign beats_n = (beats_raw == 32'd0) ? cw_lp'(1)
                   : (beats_raw > 32'(nb_lp)) ? cw_lp'(nb_lp) : beats_raw[cw_lp-1:0];

    assign hdr_hs = mem_cmd_header_v_i && state == e_ready;
    assign data_hs = mem_cmd_data_v_i && state == e_data;
    assign last_beat = cnt == beats_r - cw_lp'(1);

    assign mem_cmd_header_ready_o = reset_n_i && state == e_ready;
    assign mem_cmd_data_ready_o = state == e_data;
    assign msg_v_o = state == e_send;

    always_comb begin
        state_n = state;
        if (hdr_hs) state_n = has_data ? e_data : e_send;
        if (data_hs && last_beat) state_n = e_send;
        if (state == e_send && msg_ready_i) state_n = e_ready;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= e_ready;
            cnt <= '0;
            beats_r <= '0;
            msg_header_o <= '0;
            msg_data_o <= '0;
        end else begin
            state <= state_n;
            if (hdr_hs) begin
                msg_header_o <= mem_cmd_header_i;
                msg_data_o <= '0;
                cnt <= '0;
                beats_r <= beats_n;
            end
            if (data_hs) begin
                cnt <= cnt + cw_lp'(1);
                for (int k = 0; k < nb_lp; k++)
                    if (cnt == cw_lp'(k)) msg_data_o[k*data_width_p +: data_width_p] <= mem_cmd_data_i;
            end
        end
    end
endmodule

// File: tb/tb_bp_me_mem_cmd_burst_collector.sv
// tb_bp_me_mem_cmd_burst_collector: directed scenarios plus a randomized scoreboard run
module tb_bp_me_mem_cmd_burst_collector;
    logic clk = 1'b0;
    logic reset_n;
    logic [63:0] hdr, din, mh;
    logic hv, dv, mr, hr, dr, mv;
    logic [511:0] md;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bp_me_mem_cmd_burst_collector dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .mem_cmd_header_i(hdr), .mem_cmd_header_v_i(hv), .mem_cmd_header_ready_o(hr),
        .mem_cmd_data_i(din), .mem_cmd_data_v_i(dv), .mem_cmd_data_ready_o(dr),
        .msg_header_o(mh), .msg_data_o(md), .msg_v_o(mv), .msg_ready_i(mr)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [63:0] mk(int t, int s);
        logic [63:0] h;
        h = {$urandom, $urandom};
        h[6:3] = t[3:0];
        h[2:0] = s[2:0];
        return h;
    endfunction

    function automatic int exp_beats(int s);
        int b;
        b = (1 << s) * 8 / 64;
        if (b < 1) b = 1;
        if (b > 8) b = 8;
        return b;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; hv = 0; dv = 0; mr = 0; hdr = '0; din = '0;
        repeat (2) @(posedge clk);
        cyc();
        total++; if (hr !== 1'b0) begin bad++; $display("FAIL rst_hdr_ready got=%b exp=0", hr); end
        total++; if (dr !== 1'b0) begin bad++; $display("FAIL rst_data_ready got=%b exp=0", dr); end
        total++; if (mv !== 1'b0) begin bad++; $display("FAIL rst_msg_v got=%b exp=0", mv); end
        total++; if (mh !== 64'h0 || md !== 512'h0) begin bad++; $display("FAIL rst_payload hdr=%h data=%h exp=0", mh, md); end
        reset_n = 1'b1;
        cyc();
        total++; if (hr !== 1'b1 || dr !== 1'b0 || mv !== 1'b0) begin bad++; $display("FAIL rst_release hr=%b dr=%b v=%b exp=1,0,0", hr, dr, mv); end
    endtask

    task automatic test_read();
        logic [63:0] h;
        h = mk(0, 6); hdr = h; hv = 1; dv = 1; din = 64'h1234; mr = 1;
        cyc();
        hv = 0;
        total++; if (mv !== 1'b1) begin bad++; $display("FAIL read_v got=%b exp=1", mv); end
        total++; if (dr !== 1'b0 || hr !== 1'b0) begin bad++; $display("FAIL read_readies dr=%b hr=%b exp=0,0", dr, hr); end
        total++; if (md !== 512'h0 || mh !== h) begin bad++; $display("FAIL read_payload hdr=%h exp=%h data=%h exp=0", mh, h, md); end
        cyc();
        dv = 0;
        total++; if (mv !== 1'b0 || hr !== 1'b1 || dr !== 1'b0) begin bad++; $display("FAIL read_done v=%b hr=%b dr=%b exp=0,1,0", mv, hr, dr); end
    endtask

    task automatic test_write8();
        logic [63:0] h;
        logic [511:0] e;
        int acc, vhigh;
        h = mk(1, 6); hdr = h; hv = 1; mr = 1; e = '0; acc = 0; vhigh = 0;
        cyc();
        hv = 0;
        total++; if (dr !== 1'b1 || hr !== 1'b0 || mv !== 1'b0) begin bad++; $display("FAIL w8_enter dr=%b hr=%b v=%b exp=1,0,0", dr, hr, mv); end
        for (int k = 0; k < 8; k++) begin
            din = 64'(k); dv = 1; e[k*64 +: 64] = 64'(k);
            if (dr) acc++;
            if (mv) vhigh++;
            cyc();
        end
        dv = 0;
        total++; if (acc !== 8 || vhigh !== 0) begin bad++; $display("FAIL w8_beats accepted=%0d early_v=%0d exp=8,0", acc, vhigh); end
        total++; if (mv !== 1'b1 || dr !== 1'b0) begin bad++; $display("FAIL w8_v v=%b dr=%b exp=1,0", mv, dr); end
        total++; if (md !== e || mh !== h) begin bad++; $display("FAIL w8_payload data=%h exp=%h", md, e); end
        cyc();
        total++; if (mv !== 1'b0) begin bad++; $display("FAIL w8_done got=%b exp=0", mv); end
    endtask

    task automatic test_size3();
        logic [63:0] h, h2, b2;
        int held;
        h = mk(1, 3); hdr = h; hv = 1; dv = 1; din = 64'hDEADBEEF_CAFEF00D; mr = 0; held = 0;
        b2 = 64'h0BAD_F00D_5555_AAAA;
        cyc();
        hv = 0;
        total++; if (dr !== 1'b1 || mv !== 1'b0) begin bad++; $display("FAIL s3_enter dr=%b v=%b exp=1,0", dr, mv); end
        cyc();
        din = b2;
        total++; if (mv !== 1'b1 || dr !== 1'b0) begin bad++; $display("FAIL s3_v v=%b dr=%b exp=1,0", mv, dr); end
        total++; if (md !== {448'h0, 64'hDEADBEEF_CAFEF00D}) begin bad++; $display("FAIL s3_data got=%h", md); end
        repeat (3) begin cyc(); if (dr !== 1'b0 || hr !== 1'b0 || mv !== 1'b1) held++; end
        total++; if (held !== 0) begin bad++; $display("FAIL s3_hold bad_cycles=%0d exp=0", held); end
        mr = 1;
        cyc();
        mr = 0;
        total++; if (dr !== 1'b0 || mv !== 1'b0 || hr !== 1'b1) begin bad++; $display("FAIL s3_idle dr=%b v=%b hr=%b exp=0,0,1", dr, mv, hr); end
        h2 = mk(1, 0); hdr = h2; hv = 1;
        cyc();
        hv = 0;
        cyc();
        dv = 0;
        total++; if (mv !== 1'b1 || mh !== h2 || md !== {448'h0, b2}) begin bad++; $display("FAIL s3_second v=%b hdr=%h exp=%h data=%h", mv, mh, h2, md); end
        mr = 1;
        cyc();
        total++; if (mv !== 1'b0) begin bad++; $display("FAIL s3_done got=%b exp=0", mv); end
    endtask

    task automatic test_stall();
        logic [63:0] h, a, b;
        logic [511:0] e;
        int errs;
        h = mk(2, 4); hdr = h; hv = 1; mr = 0; errs = 0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; e = {384'h0, b, a};
        cyc();
        hv = 0; dv = 1; din = a;
        cyc();
        din = b;
        cyc();
        dv = 0;
        total++; if (mv !== 1'b1 || md !== e) begin bad++; $display("FAIL stall_v v=%b data=%h exp=%h", mv, md, e); end
        hv = 1; hdr = mk(0, 0);
        repeat (5) begin cyc(); if (mv !== 1'b1 || hr !== 1'b0 || md !== e || mh !== h) errs++; end
        total++; if (errs !== 0) begin bad++; $display("FAIL stall_hold bad_cycles=%0d exp=0", errs); end
        hv = 0; mr = 1;
        cyc();
        total++; if (mv !== 1'b0 || hr !== 1'b1) begin bad++; $display("FAIL stall_done v=%b hr=%b exp=0,1", mv, hr); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] h, w;
        logic [511:0] e;
        int errs;
        h = mk(1, 6); hdr = h; hv = 1; mr = 1; errs = 0; e = '0;
        cyc();
        hv = 0; dv = 1;
        for (int k = 0; k < 3; k++) begin din = {$urandom, $urandom}; cyc(); end
        dv = 0;
        #2 reset_n = 1'b0;
        #1;
        total++; if (mv !== 1'b0 || dr !== 1'b0 || hr !== 1'b0) begin bad++; $display("FAIL rmid_ctrl v=%b dr=%b hr=%b exp=0,0,0", mv, dr, hr); end
        total++; if (mh !== 64'h0 || md !== 512'h0) begin bad++; $display("FAIL rmid_payload hdr=%h data=%h exp=0", mh, md); end
        @(posedge clk);
        cyc();
        reset_n = 1'b1;
        repeat (4) begin cyc(); if (mv !== 1'b0 || dr !== 1'b0) errs++; end
        total++; if (errs !== 0 || hr !== 1'b1) begin bad++; $display("FAIL rmid_quiet bad_cycles=%0d hr=%b exp=0,1", errs, hr); end
        h = mk(1, 5); hdr = h; hv = 1;
        cyc();
        hv = 0; dv = 1;
        for (int k = 0; k < 4; k++) begin w = {$urandom, $urandom}; e[k*64 +: 64] = w; din = w; cyc(); end
        dv = 0;
        total++; if (mv !== 1'b1 || mh !== h || md !== e) begin bad++; $display("FAIL rmid_clean v=%b data=%h exp=%h", mv, md, e); end
        cyc();
    endtask

    task automatic test_random();
        logic [63:0] hq[$], bq[$], eh[$];
        logic [511:0] ed[$];
        logic [63:0] h, w;
        logic [511:0] d;
        logic [15:0] mask;
        int got, cycles, s, t;
        got = 0; cycles = 0; mask = 16'h0006;
        for (int m = 0; m < 1000; m++) begin
            s = $urandom_range(0, 7);
            t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 2));
            h = mk(t, s); d = '0;
            if (mask[t]) for (int j = 0; j < exp_beats(s); j++) begin
                w = {$urandom, $urandom}; bq.push_back(w); d[j*64 +: 64] = w;
            end
            hq.push_back(h); eh.push_back(h); ed.push_back(d);
        end
        while (got < 1000 && cycles < 60000) begin
            cyc();
            cycles++;
            hv = hq.size() > 0 && $urandom_range(0, 3) != 0;
            hdr = hq.size() > 0 ? hq[0] : 64'h0;
            dv = bq.size() > 0 && $urandom_range(0, 3) != 0;
            din = bq.size() > 0 ? bq[0] : 64'h0;
            mr = $urandom_range(0, 2) != 0;
            if (hv && hr) void'(hq.pop_front());
            if (dv && dr) void'(bq.pop_front());
            if (mv && mr) begin
                total++;
                if (eh.size() == 0) begin bad++; $display("FAIL rnd_extra msg hdr=%h exp=none", mh); end
                else begin
                    if (mh !== eh[0] || md !== ed[0]) begin
                        bad++; $display("FAIL rnd_msg%0d hdr=%h exp=%h data=%h exp=%h", got, mh, eh[0], md, ed[0]);
                    end
                    void'(eh.pop_front()); void'(ed.pop_front());
                end
                got++;
            end
        end
        hv = 0; dv = 0; mr = 1;
        total++; if (got !== 1000) begin bad++; $display("FAIL rnd_count got=%0d exp=1000", got); end
        total++; if (bq.size() !== 0 || hq.size() !== 0) begin bad++; $display("FAIL rnd_leftover beats=%0d hdrs=%0d exp=0,0", bq.size(), hq.size()); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write8();
        test_size3();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
